// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side buffer for a UART. Characters delivered by the deserializer
// are queued together with their parity-error flag; characters with a frame
// error are dropped. A watermark output and a receive timeout (counted in
// baud ticks while data sits idle in the FIFO) support interrupt generation.
//
// Ports
//   clk_i          sole clock, rising edge
//   rst_i          synchronous active-high reset, highest priority
//   rx_enable_i    receiver enable; when 0 new characters are ignored
//   rx_valid_i     one-cycle strobe: rx_data_i/frame_err_i/parity_err_i valid
//   rx_data_i      received character
//   frame_err_i    frame error for the strobed character (character dropped)
//   parity_err_i   parity error for the strobed character (stored with it)
//   tick_baud_i    one-cycle baud tick driving the timeout counter
//   fifo_clr_i     synchronous flush, overrides same-cycle push/pop
//   lvl_sel_i      watermark level select
//   to_en_i        receive-timeout enable
//   to_val_i       receive-timeout threshold in baud ticks (0 = never)
//   rready_i       consumer accepts the head entry
//   rvalid_o       FIFO not empty
//   rdata_o        head character (0 while empty)
//   rperr_o        parity-error flag of the head character (0 while empty)
//   depth_o        current occupancy, 0..Depth
//   watermark_o    occupancy >= selected level
//   overflow_o     one-cycle pulse: character dropped because FIFO was full
//   frame_err_o    one-cycle pulse: character dropped for a frame error
//   parity_err_o   one-cycle pulse: character received with a parity error
//   timeout_o      receive-timeout level flag
//
// Read handshake: rvalid_o/rready_i follow valid/ready rules. An entry is
// popped on every rising edge where rvalid_o and rready_i are both 1.
// rdata_o/rperr_o are driven only from registered state and stay stable
// while rvalid_o=1 and rready_i=0. rready_i while rvalid_o=0 is ignored.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int Depth = 16,
  parameter int ToW   = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rx_enable_i,
  input  logic                       rx_valid_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       frame_err_i,
  input  logic                       parity_err_i,
  input  logic                       tick_baud_i,
  input  logic                       fifo_clr_i,
  input  logic [2:0]                 lvl_sel_i,
  input  logic                       to_en_i,
  input  logic [ToW-1:0]             to_val_i,
  input  logic                       rready_i,
  output logic                       rvalid_o,
  output logic [7:0]                 rdata_o,
  output logic                       rperr_o,
  output logic [$clog2(Depth+1)-1:0] depth_o,
  output logic                       watermark_o,
  output logic                       overflow_o,
  output logic                       frame_err_o,
  output logic                       parity_err_o,
  output logic                       timeout_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [ToW-1:0]  ToMax   = '1;

  // Storage: {parity flag, character}
  logic [8:0]      mem_q [Depth];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [CntW-1:0] count_q;

  logic [ToW-1:0]  to_cnt_q;
  logic            timeout_q;
  logic            overflow_q;
  logic            frame_err_q;
  logic            parity_err_q;

  // -------------------------------------------------------------------------
  // Per-cycle decode
  // -------------------------------------------------------------------------
  logic empty;
  logic full;
  logic rx_accept;   // a character strobe the receiver looks at
  logic push_req;    // character wants to be stored
  logic pop;
  logic push_ok;     // character is actually written
  logic overflow_c;
  logic frame_err_c;
  logic parity_err_c;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

  // A flush swallows everything that arrives in its cycle, including pulses.
  assign rx_accept    = rx_valid_i & rx_enable_i & ~fifo_clr_i;
  assign push_req     = rx_accept & ~frame_err_i;
  assign pop          = ~empty & rready_i & ~fifo_clr_i;
  // At full a same-cycle pop frees the slot the push needs.
  assign push_ok      = push_req & (~full | pop);
  assign overflow_c   = push_req & full & ~pop;
  assign frame_err_c  = rx_accept & frame_err_i;
  assign parity_err_c = push_req & parity_err_i;

  // -------------------------------------------------------------------------
  // Timeout decode
  // -------------------------------------------------------------------------
  logic to_clr;
  logic to_inc;
  logic to_hit;

  assign to_clr = push_ok | pop | fifo_clr_i | ~rx_enable_i | ~to_en_i | empty;
  assign to_inc = ~to_clr & tick_baud_i & (to_cnt_q != ToMax);
  // Flag rises on the edge where the counter steps onto the threshold.
  assign to_hit = to_inc & (to_val_i != '0) & ((to_cnt_q + ToW'(1)) == to_val_i);

  // -------------------------------------------------------------------------
  // Storage array (no reset needed: contents are qualified by count_q)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) begin
      mem_q[wptr_q] <= {parity_err_i, rx_data_i};
    end
  end

  // -------------------------------------------------------------------------
  // Pointers and occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || fifo_clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop)     rptr_q <= rptr_q + PtrW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Status pulses (fifo_clr_i already masks them through rx_accept)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      overflow_q   <= overflow_c;
      frame_err_q  <= frame_err_c;
      parity_err_q <= parity_err_c;
    end
  end

  // -------------------------------------------------------------------------
  // Receive timeout
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (to_clr) begin
        to_cnt_q <= '0;
      end else if (to_inc) begin
        to_cnt_q <= to_cnt_q + ToW'(1);
      end

      // rx_enable_i=0 or a push only restart the count; the flag itself
      // is held until the consumer reacts or timeouts are disabled.
      if (pop || fifo_clr_i || !to_en_i) begin
        timeout_q <= 1'b0;
      end else if (to_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Watermark level
  // -------------------------------------------------------------------------
  logic [31:0] level;

  always_comb begin
    level = 32'd1;
    case (lvl_sel_i)
      3'd0:    level = 32'd1;
      3'd1:    level = 32'd2;
      3'd2:    level = 32'd4;
      3'd3:    level = 32'd8;
      3'd4:    level = 32'(Depth - 2);
      default: level = 32'd1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rvalid_o     = ~empty;
  assign rdata_o      = empty ? 8'h00 : mem_q[rptr_q][7:0];
  assign rperr_o      = empty ? 1'b0  : mem_q[rptr_q][8];
  assign depth_o      = count_q;
  assign watermark_o  = (32'(count_q) >= level);
  assign overflow_o   = overflow_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo. A queue-based reference model is
// stepped once per clock with the same inputs as the DUT; every cycle all
// outputs are compared against it. Directed scenarios add explicit checks
// of the documented behaviour, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int TOW   = 24;
  localparam int CW    = $clog2(DEPTH + 1);

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_i        = 1'b1;
  logic           rx_enable_i  = 1'b0;
  logic           rx_valid_i   = 1'b0;
  logic [7:0]     rx_data_i    = 8'h00;
  logic           frame_err_i  = 1'b0;
  logic           parity_err_i = 1'b0;
  logic           tick_baud_i  = 1'b0;
  logic           fifo_clr_i   = 1'b0;
  logic [2:0]     lvl_sel_i    = 3'd0;
  logic           to_en_i      = 1'b0;
  logic [TOW-1:0] to_val_i     = '0;
  logic           rready_i     = 1'b0;

  logic           rvalid_o;
  logic [7:0]     rdata_o;
  logic           rperr_o;
  logic [CW-1:0]  depth_o;
  logic           watermark_o;
  logic           overflow_o;
  logic           frame_err_o;
  logic           parity_err_o;
  logic           timeout_o;

  uart_rx_fifo #(.Depth(DEPTH), .ToW(TOW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rx_enable_i  (rx_enable_i),
    .rx_valid_i   (rx_valid_i),
    .rx_data_i    (rx_data_i),
    .frame_err_i  (frame_err_i),
    .parity_err_i (parity_err_i),
    .tick_baud_i  (tick_baud_i),
    .fifo_clr_i   (fifo_clr_i),
    .lvl_sel_i    (lvl_sel_i),
    .to_en_i      (to_en_i),
    .to_val_i     (to_val_i),
    .rready_i     (rready_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .rperr_o      (rperr_o),
    .depth_o      (depth_o),
    .watermark_o  (watermark_o),
    .overflow_o   (overflow_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .timeout_o    (timeout_o)
  );

  // -------------------------------------------------------------------------
  // Scoreboard / reference model
  // -------------------------------------------------------------------------
  logic [8:0] exp_q[$];        // {parity flag, character}, head at index 0
  longint     m_tcnt  = 0;     // idle baud ticks counted
  bit         m_tout  = 0;
  bit         m_ovf   = 0;
  bit         m_ferr  = 0;
  bit         m_perr  = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wm_level(input logic [2:0] sel);
    case (sel)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      3'd3:    return 8;
      3'd4:    return DEPTH - 2;
      default: return 1;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int  n;
    bit  strobe, pop, store;
    n      = exp_q.size();
    m_ovf  = 0;
    m_ferr = 0;
    m_perr = 0;
    if (rst_i || fifo_clr_i) begin
      exp_q.delete();
      m_tcnt = 0;
      m_tout = 0;
      return;
    end
    strobe = rx_valid_i && rx_enable_i;
    pop    = (n > 0) && rready_i;
    store  = 0;
    if (strobe && frame_err_i) m_ferr = 1;
    if (strobe && !frame_err_i) begin
      m_perr = parity_err_i;
      if (n < DEPTH || pop) store = 1;
      else                  m_ovf = 1;
    end
    if (pop)   void'(exp_q.pop_front());
    if (store) exp_q.push_back({parity_err_i, rx_data_i});

    if (store || pop || !rx_enable_i || !to_en_i || n == 0) begin
      m_tcnt = 0;
    end else if (tick_baud_i && m_tcnt < (64'd1 << TOW) - 1) begin
      m_tcnt++;
      if (to_val_i != 0 && m_tcnt == longint'(to_val_i)) m_tout = 1;
    end
    if (pop || !to_en_i) m_tout = 0;
  endtask

  task automatic compare_all();
    int n;
    n = exp_q.size();
    check("rvalid",    rvalid_o,     (n > 0));
    check("rdata",     rdata_o,      (n > 0) ? exp_q[0][7:0] : 0);
    check("rperr",     rperr_o,      (n > 0) ? exp_q[0][8]   : 0);
    check("depth",     depth_o,      n);
    check("watermark", watermark_o,  (n >= wm_level(lvl_sel_i)));
    check("overflow",  overflow_o,   m_ovf);
    check("frame_err", frame_err_o,  m_ferr);
    check("parity_err",parity_err_o, m_perr);
    check("timeout",   timeout_o,    m_tout);
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // One clock: model advances, DUT clocks, outputs compared 1 time unit
  // after the edge, then single-cycle inputs return to idle.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    rst_i        = 1'b0;
    rx_valid_i   = 1'b0;
    frame_err_i  = 1'b0;
    parity_err_i = 1'b0;
    tick_baud_i  = 1'b0;
    fifo_clr_i   = 1'b0;
    rready_i     = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input bit pe, input bit fe);
    rx_valid_i   = 1'b1;
    rx_data_i    = d;
    parity_err_i = pe;
    frame_err_i  = fe;
    step();
  endtask

  task automatic pop();
    rready_i = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick_after(input int gap);
    idle(gap);
    tick_baud_i = 1'b1;
    step();
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [7:0] order_v [3];

  initial begin
    // Reset state
    rst_i = 1'b1;
    step();
    check("rst_rvalid", rvalid_o, 0);
    check("rst_depth",  depth_o,  0);
    check("rst_tout",   timeout_o, 0);
    rx_enable_i = 1'b1;
    idle(2);

    // In-order delivery, one-cycle visibility
    order_v[0] = 8'h55; order_v[1] = 8'hA3; order_v[2] = 8'h0F;
    push(8'h55, 0, 0);
    check("first_rvalid", rvalid_o, 1);
    check("first_rdata",  rdata_o,  8'h55);
    push(8'hA3, 0, 0);
    push(8'h0F, 0, 0);
    check("three_depth", depth_o, 3);
    check("head_held",   rdata_o, 8'h55);
    for (int i = 0; i < 3; i++) begin
      check("order_data", rdata_o, order_v[i]);
      pop();
    end
    check("drained_rvalid", rvalid_o, 0);
    pop();  // pop on empty: no effect
    check("empty_pop_depth", depth_o, 0);

    // Overflow and push+pop at full
    for (int i = 0; i < DEPTH; i++) push(8'(i), 0, 0);
    check("full_depth", depth_o, DEPTH);
    push(8'h77, 0, 0);
    check("ovf_pulse", overflow_o, 1);
    check("ovf_depth", depth_o, DEPTH);
    step();
    check("ovf_once", overflow_o, 0);
    rx_valid_i = 1'b1; rx_data_i = 8'h20; rready_i = 1'b1;
    step();
    check("pp_full_ovf",   overflow_o, 0);
    check("pp_full_depth", depth_o, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      check("no_77", (rdata_o == 8'h77), 0);
      pop();
    end

    // Frame and parity errors
    push(8'h3C, 0, 1);
    check("ferr_pulse", frame_err_o, 1);
    check("ferr_depth", depth_o, 0);
    push(8'h12, 1, 0);
    check("perr_pulse", parity_err_o, 1);
    check("perr_rdata", rdata_o, 8'h12);
    check("perr_rperr", rperr_o, 1);
    pop();

    // Watermark at level 4
    lvl_sel_i = 3'd2;
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i), 0, 0);
    check("wm_3", watermark_o, 0);
    push(8'h33, 0, 0);
    check("wm_4", watermark_o, 1);
    pop();
    check("wm_pop", watermark_o, 0);
    idle(1);
    for (int i = 0; i < 3; i++) pop();
    lvl_sel_i = 3'd0;

    // Receive timeout
    to_en_i = 1'b1; to_val_i = TOW'(4);
    push(8'h41, 0, 0);
    for (int t = 1; t <= 4; t++) begin
      tick_after(15);
      check("to_tick", timeout_o, (t == 4));
    end
    idle(3);
    check("to_held", timeout_o, 1);
    pop();
    check("to_pop_clear", timeout_o, 0);
    push(8'h42, 0, 0);
    for (int t = 0; t < 3; t++) tick_after(15);
    push(8'h43, 0, 0);
    for (int t = 0; t < 3; t++) tick_after(15);
    check("to_restart", timeout_o, 0);
    tick_after(15);
    check("to_restart_hit", timeout_o, 1);
    to_val_i = '0;
    pop();
    for (int t = 0; t < 6; t++) tick_after(2);
    check("to_zero_never", timeout_o, 0);
    pop();
    to_en_i = 1'b0;

    // Flush overriding a push, then reset mid-fill
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 0, 0);
    rx_valid_i = 1'b1; rx_data_i = 8'h99; fifo_clr_i = 1'b1;
    step();
    check("clr_depth",  depth_o,  0);
    check("clr_rvalid", rvalid_o, 0);
    for (int i = 0; i < 3; i++) push(8'(8'h70 + i), 1, 0);
    rst_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'h88;
    step();
    check("rst_mid_depth",  depth_o,  0);
    check("rst_mid_rvalid", rvalid_o, 0);
    check("rst_mid_rdata",  rdata_o,  0);
    check("rst_mid_perr",   parity_err_o, 0);

    // Randomized traffic in phases with different pop pressure
    for (int ph = 0; ph < 8; ph++) begin
      int pop_pct;
      pop_pct  = (ph % 2 == 0) ? 8 : 45;
      lvl_sel_i = 3'($urandom_range(0, 7));
      to_en_i   = ($urandom_range(0, 3) != 0);
      to_val_i  = TOW'($urandom_range(0, 6));
      for (int c = 0; c < 300; c++) begin
        rx_enable_i  = ($urandom_range(0, 9) != 0);
        rx_valid_i   = ($urandom_range(0, 99) < 35);
        rx_data_i    = 8'($urandom_range(0, 255));
        frame_err_i  = ($urandom_range(0, 9) == 0);
        parity_err_i = ($urandom_range(0, 6) == 0);
        rready_i     = ($urandom_range(0, 99) < pop_pct);
        tick_baud_i  = ($urandom_range(0, 3) == 0);
        fifo_clr_i   = ($urandom_range(0, 199) == 0);
        rst_i        = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 99) == 0) to_en_i = ~to_en_i;
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
